aes_inv_sbox_sched: RTL and testbench

Scheduler that shares one 32-bit inverse S-box word lookup between two requesters, such as the decipher round datapath and a second decipher lane or test port. It accepts 128-bit blocks and arbitrates between the requesters, round-robin or fixed priority. It then sequences the four 32-bit words of the granted block through the external inverse S-box, one word per cycle, and returns the InvSubBytes result on a single response channel. It sits between the decipher control logic and the combinational inverse S-box instance.

---
 rtl/aes_inv_sbox_sched.sv | 125 ++++++++++++
 tb/tb_aes_inv_sbox_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_sbox_sched.sv
// Shares one 32-bit inverse S-box lookup between two 128-bit block requesters.
// A granted block is pushed through the S-box one word per cycle, MSB word first.
module aes_inv_sbox_sched #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [127:0] req0_block,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_block,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [127:0] rsp_block,
  input  logic         rsp_ready,
  output logic [31:0]  sbox_word,
  input  logic [31:0]  sbox_new_word,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q;
  logic [1:0]   widx_q;
  logic [1:0]   widx_d;
  logic         last_grant_q;
  logic         id_q;
  logic         rsp_valid_q;
  logic         busy_q;
  logic [127:0] blk_q;
  logic [127:0] res_q;
  logic [31:0]  sbox_word_q;

  logic         grant0;
  logic         grant1;
  logic         accept;
  logic [127:0] grant_blk;

  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
    case (idx)
      2'd0:    word_sel = blk[127:96];
      2'd1:    word_sel = blk[95:64];
      2'd2:    word_sel = blk[63:32];
      default: word_sel = blk[31:0];
    endcase
  endfunction

  // Requester 1 wins only when alone, or on a round-robin tie after requester 0 was served.
  always_comb begin
    grant1 = req1_valid & (~req0_valid | ((FIXED_PRIO == 1'b0) & ~last_grant_q));
    grant0 = req0_valid & ~grant1;
  end

  assign req0_ready = (state_q == IDLE) & ~reset & grant0;
  assign req1_ready = (state_q == IDLE) & ~reset & grant1;
  assign accept     = req0_ready | req1_ready;
  assign grant_blk  = grant1 ? req1_block : req0_block;
  assign widx_d     = widx_q + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      widx_q       <= 2'd0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      blk_q        <= '0;
      res_q        <= '0;
      sbox_word_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= SUB;
            widx_q       <= 2'd0;
            blk_q        <= grant_blk;
            id_q         <= grant1;
            last_grant_q <= grant1;
            busy_q       <= 1'b1;
            sbox_word_q  <= grant_blk[127:96];
          end
        end
        SUB: begin
          case (widx_q)
            2'd0:    res_q[127:96] <= sbox_new_word;
            2'd1:    res_q[95:64]  <= sbox_new_word;
            2'd2:    res_q[63:32]  <= sbox_new_word;
            default: res_q[31:0]   <= sbox_new_word;
          endcase
          widx_q <= widx_d;
          // The S-box input is parked at zero once the last word has been looked up.
          if (widx_q == 2'd3) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            sbox_word_q <= '0;
          end else begin
            sbox_word_q <= word_sel(blk_q, widx_d);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_block = res_q;
  assign sbox_word = sbox_word_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_sbox_sched.sv
// Scoreboard bench: lane 0 runs round-robin, lane 1 fixed priority; each lane has its
// own inverse S-box model, expected-response queue and monitor.
module tb_aes_inv_sbox_sched;

  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [127:0] BLK_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] EXP_A = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] BLK_B = {16{8'h63}};
  localparam logic [127:0] EXP_B = '0;
  localparam logic [127:0] BLK_C = {16{8'hff}};
  localparam logic [127:0] EXP_C = {16{8'h7d}};
  localparam logic [127:0] BLK_D = '0;
  localparam logic [127:0] EXP_D = {16{8'h52}};
  localparam logic [127:0] BLK_E = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] EXP_E = 128'h7ce339829b2fff87348e4344c4dee9cb;

  logic         clk;
  logic         reset;
  logic         r0v  [2];
  logic [127:0] r0b  [2];
  logic         r0r  [2];
  logic         r1v  [2];
  logic [127:0] r1b  [2];
  logic         r1r  [2];
  logic         rv   [2];
  logic         rid  [2];
  logic [127:0] rb   [2];
  logic         rrdy [2];
  logic [31:0]  sw   [2];
  logic [31:0]  snw  [2];
  logic         bsy  [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    logic [128:0] exp_q [$];
    int           acc_q [$];

    aes_inv_sbox_sched #(.FIXED_PRIO(g == 1)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (r0v[g]),
      .req0_block   (r0b[g]),
      .req0_ready   (r0r[g]),
      .req1_valid   (r1v[g]),
      .req1_block   (r1b[g]),
      .req1_ready   (r1r[g]),
      .rsp_valid    (rv[g]),
      .rsp_id       (rid[g]),
      .rsp_block    (rb[g]),
      .rsp_ready    (rrdy[g]),
      .sbox_word    (sw[g]),
      .sbox_new_word(snw[g]),
      .busy         (bsy[g])
    );

    assign snw[g] = {INV[sw[g][31:24]], INV[sw[g][23:16]], INV[sw[g][15:8]], INV[sw[g][7:0]]};

    initial begin
      logic         pv;
      logic         pr;
      logic         pid;
      logic [127:0] pb;
      logic [128:0] e;
      int           a;
      pv = 1'b0; pr = 1'b0; pid = 1'b0; pb = '0;
      forever begin
        @(negedge clk);
        if (reset) begin
          pv = 1'b0;
          pr = 1'b0;
        end else begin
          if (r0r[g] || r1r[g]) begin
            chk("ready_excl_busy", {r0r[g] & r1r[g], bsy[g]}, 2'b00);
            if ((r0v[g] && r0r[g]) || (r1v[g] && r1r[g])) acc_q.push_back(cyc);
          end
          if (rv[g] && !pv) begin
            if (acc_q.size() == 0) chk("latency_orphan", 1, 0);
            else begin
              a = acc_q.pop_front();
              chk("latency", cyc, a + 5);
            end
          end
          if (rv[g] && pv && !pr) begin
            chk("hold_id", rid[g], pid);
            chk("hold_blk", rb[g], pb);
          end
          if (rv[g] && rrdy[g]) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
              e = exp_q.pop_front();
              chk("rsp_id", rid[g], e[128]);
              chk("rsp_blk", rb[g], e[127:0]);
            end
          end
          pv = rv[g]; pr = rrdy[g]; pid = rid[g]; pb = rb[g];
        end
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic expect_rsp(input int inst, input logic id, input logic [127:0] blk);
    if (inst == 0) lane[0].exp_q.push_back({id, blk});
    else           lane[1].exp_q.push_back({id, blk});
  endtask

  // Called at posedge+2; holds valid until accepted, returns the accept cycle.
  task automatic issue(input int inst, input int port, input logic [127:0] blk, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    if (port == 0) begin r0v[inst] = 1'b1; r0b[inst] = blk; end
    else           begin r1v[inst] = 1'b1; r1b[inst] = blk; end
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if ((port == 0) ? r0r[inst] : r1r[inst]) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    if (port == 0) r0v[inst] = 1'b0;
    else           r1v[inst] = 1'b0;
  endtask

  task automatic wait_idle(input int inst);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (!bsy[inst] && !rv[inst]) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  initial begin
    int a0, a1, a2, a3, h;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r0v[i] = 1'b0; r0b[i] = '0; r1v[i] = 1'b0; r1b[i] = '0; rrdy[i] = 1'b1;
    end
    r0v[0] = 1'b1; r0b[0] = BLK_A;
    repeat (3) @(negedge clk);
    chk("rst_ready0", r0r[0], 0);
    chk("rst_rsp_valid", rv[0], 0);
    chk("rst_rsp_id", rid[0], 0);
    chk("rst_rsp_blk", rb[0], '0);
    chk("rst_sbox_word", sw[0], 0);
    chk("rst_busy", bsy[0], 0);
    @(posedge clk); #2;
    r0v[0] = 1'b0;
    reset = 1'b0;
    @(posedge clk); #2;

    // Single requests with known-answer blocks.
    expect_rsp(0, 1'b0, EXP_A);
    issue(0, 0, BLK_A, a0);
    @(negedge clk);
    chk("sub_word0", sw[0], 32'h00010203);
    wait_idle(0);
    expect_rsp(0, 1'b1, EXP_B);
    issue(0, 1, BLK_B, a0);
    wait_idle(0);
    expect_rsp(0, 1'b1, EXP_C);
    issue(0, 1, BLK_C, a0);
    wait_idle(0);

    // Round-robin tie: both valid continuously.
    expect_rsp(0, 1'b0, EXP_A);
    expect_rsp(0, 1'b1, EXP_E);
    expect_rsp(0, 1'b0, EXP_C);
    expect_rsp(0, 1'b1, EXP_B);
    fork
      begin issue(0, 0, BLK_A, a0); issue(0, 0, BLK_C, a2); end
      begin issue(0, 1, BLK_E, a1); issue(0, 1, BLK_B, a3); end
    join
    chk("rr_gap_0_1", a1 - a0, 6);
    chk("rr_gap_1_2", a2 - a1, 6);
    chk("rr_gap_2_3", a3 - a2, 6);
    wait_idle(0);

    // Fixed priority tie on lane 1.
    expect_rsp(1, 1'b0, EXP_A);
    expect_rsp(1, 1'b0, EXP_D);
    expect_rsp(1, 1'b1, EXP_E);
    fork
      begin issue(1, 0, BLK_A, a0); issue(1, 0, BLK_D, a1); end
      issue(1, 1, BLK_E, a2);
    join
    chk("fp_gap_0_1", a1 - a0, 6);
    chk("fp_gap_1_2", a2 - a1, 6);
    wait_idle(1);

    // Backpressure: stall DONE for 10 cycles with req1 pending.
    rrdy[0] = 1'b0;
    h = -100;
    expect_rsp(0, 1'b0, EXP_A);
    expect_rsp(0, 1'b1, EXP_B);
    issue(0, 0, BLK_A, a0);
    fork
      issue(0, 1, BLK_B, a1);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (rv[0]) break;
        end
        chk("bp_reach_done", rv[0], 1);
        repeat (9) @(negedge clk);
        @(posedge clk); #2;
        rrdy[0] = 1'b1;
        h = cyc;
      end
    join
    chk("bp_accept_after_hs", a1, h + 1);
    wait_idle(0);

    // Reset while widx=2 discards the in-flight block.
    issue(0, 0, BLK_A, a0);
    @(negedge clk);
    chk("sub_word0_b", sw[0], 32'h00010203);
    @(posedge clk); #2;
    @(negedge clk);
    chk("sub_word1", sw[0], 32'h04050607);
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    chk("sub_word2", sw[0], 32'h08090a0b);
    @(posedge clk); #2;
    reset = 1'b0;
    lane[0].acc_q.delete();
    lane[0].exp_q.delete();
    @(negedge clk);
    chk("mrst_rsp_valid", rv[0], 0);
    chk("mrst_busy", bsy[0], 0);
    chk("mrst_sbox_word", sw[0], 0);
    @(posedge clk); #2;
    expect_rsp(0, 1'b0, EXP_D);
    expect_rsp(0, 1'b1, EXP_E);
    fork
      issue(0, 0, BLK_D, a0);
      issue(0, 1, BLK_E, a1);
    join
    chk("mrst_tie_gap", a1 - a0, 6);
    wait_idle(0);
    wait_idle(1);

    chk("lane0_drained", lane[0].exp_q.size(), 0);
    chk("lane1_drained", lane[1].exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
